// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state type, line geometry and helpers for the direct-mapped data cache
package dcache_pkg;
   typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_e;
   localparam int OFFSET_W = 2;
   localparam int LINE_W = 128;
   localparam int WORD_W = 32;
   function automatic int tag_w(input int addr_w, input int index_w);
      return addr_w - index_w - OFFSET_W;
   endfunction
   function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line, input logic [OFFSET_W-1:0] off);
      return line[WORD_W*off +: WORD_W];
   endfunction
endpackage

// File: rtl/dcache_if.sv
// dcache_if: CPU load/store and block-memory signals of the data cache
// DCACHE_STATS_EN adds the hit_count/miss_count outputs
interface dcache_if #(parameter int ADDR_W = 10);
   import dcache_pkg::*;
   logic cpu_rd;
   logic cpu_wr;
   logic [ADDR_W-1:0] cpu_addr;
   logic [WORD_W-1:0] cpu_wdata;
   logic [WORD_W-1:0] cpu_rdata;
   logic stall;
   logic mem_rd_en;
   logic mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic mem_done;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
   modport master (output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_done,
                   input cpu_rdata, stall, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, hit_count, miss_count);
   modport slave (input cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_done,
                  output cpu_rdata, stall, mem_rd_en, mem_wr_en, mem_addr, mem_wdata, hit_count, miss_count);
`else
   modport master (output cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_done,
                   input cpu_rdata, stall, mem_rd_en, mem_wr_en, mem_addr, mem_wdata);
   modport slave (input cpu_rd, cpu_wr, cpu_addr, cpu_wdata, mem_rdata, mem_done,
                  output cpu_rdata, stall, mem_rd_en, mem_wr_en, mem_addr, mem_wdata);
`endif
endinterface

// File: rtl/dcache_line_array.sv
// dcache_line_array: valid/tag/data storage with a combinational read port,
// a full-line fill port and a single-word update port (fill wins on collision)
module dcache_line_array
   import dcache_pkg::*;
#(
   parameter int INDEX_W = 5,
   parameter int TAG_W = 3
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [INDEX_W-1:0]  idx_i,
   input  logic [OFFSET_W-1:0] off_i,
   output logic                valid_o,
   output logic [TAG_W-1:0]    tag_o,
   output logic [LINE_W-1:0]   line_o,
   input  logic                line_we_i,
   input  logic [TAG_W-1:0]    line_tag_i,
   input  logic [LINE_W-1:0]   line_data_i,
   input  logic                word_we_i,
   input  logic [WORD_W-1:0]   word_data_i
);
   localparam int LINES = 2**INDEX_W;
   localparam int WORDS = LINE_W / WORD_W;
   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_q [LINES];
   logic [WORDS-1:0][WORD_W-1:0] data_q [LINES];
   assign valid_o = valid_q[idx_i];
   assign tag_o = tag_q[idx_i];
   assign line_o = data_q[idx_i];
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) valid_q <= '0;
      else if (line_we_i) valid_q[idx_i] <= 1'b1;
   // tag/data need no reset: nothing reads them while the line is invalid
   always_ff @(posedge clk_i)
      if (line_we_i) begin
         tag_q[idx_i] <= line_tag_i;
         data_q[idx_i] <= line_data_i;
      end else if (word_we_i) data_q[idx_i][off_i] <= word_data_i;
endmodule

// File: rtl/data_cache_controller.sv
// data_cache_controller: direct-mapped, write-through, no-write-allocate L1 data cache
// DCACHE_STATS_EN adds wrapping hit/miss counters on the interface
module data_cache_controller
   import dcache_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int INDEX_W = 5
) (
   input logic clk_i,
   input logic rst_ni,
   dcache_if.slave bus
);
   localparam int TAG_W = tag_w(ADDR_W, INDEX_W);
   state_e state_q, state_d;
   logic [OFFSET_W-1:0] off;
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0] tag, line_tag;
   logic [LINE_W-1:0] line_data;
   logic line_valid, hit, line_we, word_we, hit_inc, miss_inc;
   assign off = bus.cpu_addr[OFFSET_W-1:0];
   assign idx = bus.cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
   assign tag = bus.cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W];
   assign hit = line_valid && line_tag == tag;
   assign bus.mem_addr = bus.cpu_addr;
   assign bus.mem_wdata = bus.cpu_wdata;
   dcache_line_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_lines (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .idx_i       (idx),
      .off_i       (off),
      .valid_o     (line_valid),
      .tag_o       (line_tag),
      .line_o      (line_data),
      .line_we_i   (line_we),
      .line_tag_i  (tag),
      .line_data_i (bus.mem_rdata),
      .word_we_i   (word_we),
      .word_data_i (bus.cpu_wdata)
   );
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) state_q <= IDLE;
      else state_q <= state_d;
   // outputs are forced quiet while reset is asserted, even with a request held
   always_comb begin
      state_d = state_q;
      bus.stall = 1'b0;
      bus.mem_rd_en = 1'b0;
      bus.mem_wr_en = 1'b0;
      bus.cpu_rdata = '0;
      line_we = 1'b0;
      word_we = 1'b0;
      hit_inc = 1'b0;
      miss_inc = 1'b0;
      if (rst_ni) begin
         case (state_q)
            IDLE: begin
               if (bus.cpu_wr) begin
                  bus.stall = 1'b1;
                  state_d = WR_THRU;
               end else if (bus.cpu_rd && hit) begin
                  bus.cpu_rdata = word_sel(line_data, off);
                  hit_inc = 1'b1;
               end else if (bus.cpu_rd) begin
                  bus.stall = 1'b1;
                  state_d = RD_MISS;
               end
            end
            RD_MISS: begin
               bus.mem_rd_en = !bus.mem_done;
               bus.stall = !bus.mem_done;
               if (bus.mem_done) begin
                  bus.cpu_rdata = word_sel(bus.mem_rdata, off);
                  line_we = 1'b1;
                  miss_inc = 1'b1;
                  state_d = IDLE;
               end
            end
            WR_THRU: begin
               bus.mem_wr_en = !bus.mem_done;
               bus.stall = !bus.mem_done;
               if (bus.mem_done) begin
                  word_we = hit;
                  hit_inc = hit;
                  miss_inc = !hit;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         hit_cnt_q <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_q + 32'(hit_inc);
         miss_cnt_q <= miss_cnt_q + 32'(miss_inc);
      end
   assign bus.hit_count = hit_cnt_q;
   assign bus.miss_count = miss_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = hit_inc ^ miss_inc;
`endif
endmodule

// File: tb/tb_data_cache_controller.sv
// tb_data_cache_controller: directed and random load/store traffic against a 4-cycle
// block memory, checked by a cache model that tracks which line each index holds
module tb_data_cache_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;
   dcache_if dif ();
   data_cache_controller dut (.clk_i(clk), .rst_ni(rst_n), .bus(dif));
   logic [31:0] mem_words [1024];
   logic [31:0] ref_mem [1024];
   bit ref_valid [32];
   logic [9:0] ref_base [32];
   int ref_hits, ref_misses, mem_cnt;
   int n_checks = 0;
   int n_pass = 0;
   int unsigned salt;
   function automatic logic [31:0] mem_init_val(input int i);
      return (32'(i) * 32'h9E3779B1) ^ salt;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   // block memory: four enabled cycles, then a one-cycle mem_done carrying the line
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         mem_cnt <= 0;
         dif.mem_done <= 1'b0;
         dif.mem_rdata <= '0;
         for (int i = 0; i < 1024; i++) mem_words[i] <= mem_init_val(i);
      end else begin
         dif.mem_done <= 1'b0;
         if (dif.mem_rd_en || dif.mem_wr_en) begin
            if (mem_cnt == 3) begin
               mem_cnt <= 0;
               dif.mem_done <= 1'b1;
               if (dif.mem_wr_en) mem_words[dif.mem_addr] <= dif.mem_wdata;
               dif.mem_rdata <= {mem_words[{dif.mem_addr[9:2], 2'd3}], mem_words[{dif.mem_addr[9:2], 2'd2}],
                                 mem_words[{dif.mem_addr[9:2], 2'd1}], mem_words[{dif.mem_addr[9:2], 2'd0}]};
            end else mem_cnt <= mem_cnt + 1;
         end
      end
   task automatic init_model();
      for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = mem_init_val(i);
      ref_hits = 0;
      ref_misses = 0;
   endtask
   task automatic op(input bit rd, input bit wr, input logic [9:0] a, input logic [31:0] d);
      int idx = int'(a[6:2]);
      logic [9:0] base = {a[9:2], 2'b00};
      bit line_hit = ref_valid[idx] && ref_base[idx] == base;
      bit rd_hit = rd && !wr && line_hit;
      int exp_stall = ((rd || wr) && !rd_hit) ? 5 : 0;
      int stalls = 0, rd_cyc = 0, wr_cyc = 0, both = 0;
      @(negedge clk);
      dif.cpu_rd = rd;
      dif.cpu_wr = wr;
      dif.cpu_addr = a;
      dif.cpu_wdata = d;
      #1;
      while (dif.stall && stalls < 50) begin
         rd_cyc += int'(dif.mem_rd_en);
         wr_cyc += int'(dif.mem_wr_en);
         both += int'(dif.mem_rd_en && dif.mem_wr_en);
         stalls++;
         @(negedge clk);
         #1;
      end
      check("stall_cycles", 32'(stalls), 32'(exp_stall));
      check("rd_en_cycles", 32'(rd_cyc), (rd && !wr && !rd_hit) ? 32'd4 : 32'd0);
      check("wr_en_cycles", 32'(wr_cyc), wr ? 32'd4 : 32'd0);
      check("both_en", 32'(both), 32'd0);
      check("en_at_done", {30'd0, dif.mem_rd_en, dif.mem_wr_en}, 32'd0);
      check("rdata", dif.cpu_rdata, (rd && !wr) ? ref_mem[a] : 32'd0);
      @(posedge clk);
      #1;
      dif.cpu_rd = 1'b0;
      dif.cpu_wr = 1'b0;
      if (wr) begin
         ref_mem[a] = d;
         if (line_hit) ref_hits++;
         else ref_misses++;
         check("mem_word", mem_words[a], d);
      end else if (rd) begin
         if (rd_hit) ref_hits++;
         else begin
            ref_misses++;
            ref_valid[idx] = 1'b1;
            ref_base[idx] = base;
         end
      end
   endtask
   initial begin
      salt = $urandom;
      dif.cpu_rd = 1'b0;
      dif.cpu_wr = 1'b0;
      dif.cpu_addr = '0;
      dif.cpu_wdata = '0;
      #1 rst_n = 1'b0;
      init_model();
      #1;
      check("rst_stall", 32'(dif.stall), 32'd0);
      check("rst_rd_en", 32'(dif.mem_rd_en), 32'd0);
      check("rst_wr_en", 32'(dif.mem_wr_en), 32'd0);
      check("rst_rdata", dif.cpu_rdata, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      op(1, 0, 10'h040, 0);
      op(1, 0, 10'h040, 0);
      op(1, 0, 10'h043, 0);
      op(1, 0, 10'h0C0, 0);
      op(1, 0, 10'h040, 0);
      op(0, 1, 10'h041, 32'hDEADBEEF);
      op(1, 0, 10'h041, 0);
      op(0, 1, 10'h200, 32'hDEADBEEF);
      op(1, 0, 10'h200, 0);
      op(1, 1, 10'h045, 32'h12345678);
      op(1, 0, 10'h045, 0);
      op(0, 0, 10'h000, 0);
      // abort a refill with reset; the previously cached 0x040 must miss afterwards
      @(negedge clk);
      dif.cpu_rd = 1'b1;
      dif.cpu_addr = 10'h0C1;
      repeat (3) @(negedge clk);
      check("pre_rst_stall", 32'(dif.stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_stall", 32'(dif.stall), 32'd0);
      check("mid_rst_rd_en", 32'(dif.mem_rd_en), 32'd0);
      check("mid_rst_wr_en", 32'(dif.mem_wr_en), 32'd0);
      check("mid_rst_rdata", dif.cpu_rdata, 32'd0);
      dif.cpu_rd = 1'b0;
      init_model();
      @(negedge clk);
      rst_n = 1'b1;
      op(1, 0, 10'h040, 0);
      for (int n = 0; n < 400; n++) begin
         int k = int'($urandom_range(0, 11));
         logic [9:0] a = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 2'($urandom)};
         op(k < 7, k >= 7 && k < 11, a, $urandom);
      end
`ifdef DCACHE_STATS_EN
      check("hit_count", dif.hit_count, 32'(ref_hits));
      check("miss_count", dif.miss_count, 32'(ref_misses));
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
